// File: rtl/sa_nxn_os.sv
// NxN output-stationary systolic array: skewed A/B feeds, per-PE MAC accumulators,
// load/compute/flush/drain sequencing with valid/ready on both sides.
module sa_nxn_os #(
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 24,
  parameter int unsigned KW  = 8,
  parameter int unsigned SAT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DW-1:0]           din,
  input  logic [N*DW-1:0]           win,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [AW-1:0]             out_data,
  output logic [$clog2(N)-1:0]      out_row,
  output logic [$clog2(N)-1:0]      out_col,
  output logic                      done
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned FW = $clog2(2 * N);
  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   beats_q, beats_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [IW-1:0]   row_q, row_d, col_q, col_d;
  logic            busy_q, busy_d, in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d, done_q, done_d;
  logic            job_start;
  logic            beat_acc;
  logic            drain_hs;
  logic            adv;

  assign beat_acc = in_ready_q & in_valid;
  assign drain_hs = out_valid_q & out_ready;
  assign adv      = (state_q == S_COMPUTE) || (state_q == S_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beats_q     <= '0;
      flush_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      flush_q     <= flush_d;
      row_q       <= row_d;
      col_q       <= col_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    flush_d   = flush_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = 1'b0;
    job_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          job_start = 1'b1;
          beats_d   = k_len;
          flush_d   = '0;
          row_d     = '0;
          col_d     = '0;
          state_d   = (k_len == '0) ? S_DRAIN : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (beat_acc) begin
          beats_d = beats_q - KW'(1);
          if (beats_q == KW'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Last beat needs 2N-2 more advances to reach PE(N-1,N-1).
        if (flush_q == FW'(2 * N - 2)) begin
          flush_d = '0;
          state_d = S_DRAIN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_hs) begin
          if (col_q == IW'(N - 1)) begin
            col_d = '0;
            if (row_q == IW'(N - 1)) begin
              row_d   = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + IW'(1);
            end
          end else begin
            col_d = col_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_COMPUTE);
    out_valid_d = (state_d == S_DRAIN);
  end

  // Edge inputs: a bubble (no accepted beat) injects zeros.
  logic [DW-1:0] a_in [N];
  logic [DW-1:0] b_in [N];
  logic [DW-1:0] a_sk [N];
  logic [DW-1:0] b_sk [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = beat_acc ? din[i*DW +: DW] : '0;
      b_in[i] = beat_acc ? win[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_sk[i] = a_in[i];
      assign b_sk[i] = b_in[i];
    end else begin : g_delay
      logic [DW-1:0] sa_q [i];
      logic [DW-1:0] sb_q [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) begin
            sa_q[s] <= '0;
            sb_q[s] <= '0;
          end
        end else if (job_start) begin
          for (int s = 0; s < i; s++) begin
            sa_q[s] <= '0;
            sb_q[s] <= '0;
          end
        end else if (adv) begin
          sa_q[0] <= a_in[i];
          sb_q[0] <= b_in[i];
          for (int s = 1; s < i; s++) begin
            sa_q[s] <= sa_q[s-1];
            sb_q[s] <= sb_q[s-1];
          end
        end
      end
      assign a_sk[i] = sa_q[i-1];
      assign b_sk[i] = sb_q[i-1];
    end
  end

  // PE grid: d flows right, w flows down; the last column/row has no onward register.
  logic [DW-1:0] d_q    [N][N-1];
  logic [DW-1:0] w_q    [N-1][N];
  logic [AW-1:0] acc_q  [N][N];
  logic [DW-1:0] d_in   [N][N];
  logic [DW-1:0] w_in   [N][N];
  logic [PW-1:0] prod   [N][N];
  logic [AW:0]   sum    [N][N];
  logic [AW-1:0] acc_nx [N][N];

  always_comb begin
    for (int r = 0; r < N; r++) begin
      d_in[r][0] = a_sk[r];
      for (int c = 1; c < N; c++) d_in[r][c] = d_q[r][c-1];
    end
    for (int c = 0; c < N; c++) begin
      w_in[0][c] = b_sk[c];
      for (int r = 1; r < N; r++) w_in[r][c] = w_q[r-1][c];
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        prod[r][c]   = PW'(d_in[r][c]) * PW'(w_in[r][c]);
        sum[r][c]    = {1'b0, acc_q[r][c]} + (AW+1)'(prod[r][c]);
        acc_nx[r][c] = ((SAT != 0) && sum[r][c][AW]) ? '1 : sum[r][c][AW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || job_start) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) acc_q[r][c] <= '0;
        for (int c = 0; c < N - 1; c++) d_q[r][c] <= '0;
      end
      for (int r = 0; r < N - 1; r++)
        for (int c = 0; c < N; c++) w_q[r][c] <= '0;
    end else if (adv) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) acc_q[r][c] <= acc_nx[r][c];
        for (int c = 0; c < N - 1; c++) d_q[r][c] <= d_in[r][c];
      end
      for (int r = 0; r < N - 1; r++)
        for (int c = 0; c < N; c++) w_q[r][c] <= w_in[r][c];
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_data  = acc_q[row_q][col_q];

endmodule

// File: tb/tb_sa_nxn_os.sv
// Directed bench for sa_nxn_os (N=2, AW=16): saturating and wrapping instances in lockstep.
module tb_sa_nxn_os;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned KW = 8;

  logic              clk, rst, start, in_valid, out_ready;
  logic [KW-1:0]     k_len;
  logic [N*DW-1:0]   din, win;
  logic              a_busy, a_in_ready, a_out_valid, a_done;
  logic              b_busy, b_in_ready, b_out_valid, b_done;
  logic [AW-1:0]     a_out_data, b_out_data;
  logic [0:0]        a_out_row, a_out_col, b_out_row, b_out_col;

  sa_nxn_os #(.N(N), .DW(DW), .AW(AW), .KW(KW), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(a_busy),
    .in_valid(in_valid), .in_ready(a_in_ready), .din(din), .win(win),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_row(a_out_row), .out_col(a_out_col), .done(a_done)
  );

  sa_nxn_os #(.N(N), .DW(DW), .AW(AW), .KW(KW), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(b_busy),
    .in_valid(in_valid), .in_ready(b_in_ready), .din(din), .win(win),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_row(b_out_row), .out_col(b_out_col), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       k;
    logic             gap;
    logic             rnd;
    logic [3:0][15:0] din;
    logic [3:0][15:0] win;
    logic [3:0][15:0] exp_s;
    logic [3:0][15:0] exp_w;
  } vec_t;

  vec_t vecs [6];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_job = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL job%0d %s: got %0d expected %0d", cur_job, name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int          t, cyc, n;
    logic        vld, rdy, stalled;
    logic [15:0] held;
    logic [1:0]  held_rc;
    start = 1'b1;
    k_len = v.k;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {a_busy, b_busy}, 2'b11);
    chk("done_low_in_job", {a_done, b_done}, 2'b00);
    t = 0;
    cyc = 0;
    while (t < int'(v.k) && cyc < 40) begin
      chk("in_ready_compute", {a_in_ready, b_in_ready}, 2'b11);
      vld = !(v.gap && (cyc % 2 == 1));
      in_valid = vld;
      din = vld ? v.din[t] : 16'hFFFF;
      win = vld ? v.win[t] : 16'hFFFF;
      @(negedge clk);
      if (vld) t++;
      cyc++;
    end
    in_valid = 1'b0;
    din = '0;
    win = '0;
    chk("beats_accepted", t, int'(v.k));
    chk("in_ready_after_last", {a_in_ready, b_in_ready}, 2'b00);
    cyc = 0;
    while (!a_out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("out_valid_reached", {a_out_valid, b_out_valid}, 2'b11);
    n = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    held_rc = '0;
    while (n < 4 && cyc < 200) begin
      chk("out_valid_in_drain", a_out_valid, 1);
      if (stalled) begin
        chk("stall_data_stable", a_out_data, held);
        chk("stall_index_stable", {a_out_row, a_out_col}, held_rc);
      end
      rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (rdy) begin
        chk("result_sat", a_out_data, v.exp_s[n]);
        chk("result_wrap", b_out_data, v.exp_w[n]);
        chk("result_row", a_out_row, n / 2);
        chk("result_col", a_out_col, n % 2);
        n++;
        stalled = 1'b0;
      end else begin
        held = a_out_data;
        held_rc = {a_out_row, a_out_col};
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    chk("results_drained", n, 4);
    chk("done_pulse", {a_done, b_done}, 2'b11);
    chk("busy_low_at_done", {a_busy, b_busy}, 2'b00);
    chk("out_valid_low_at_done", a_out_valid, 0);
  endtask

  initial begin
    vecs[0] = '0;
    vecs[0].k = 8'd2;
    vecs[0].din[0] = 16'h0301; vecs[0].win[0] = 16'h0605;
    vecs[0].din[1] = 16'h0402; vecs[0].win[1] = 16'h0807;
    vecs[0].exp_s[0] = 16'd19; vecs[0].exp_s[1] = 16'd22;
    vecs[0].exp_s[2] = 16'd43; vecs[0].exp_s[3] = 16'd50;
    vecs[0].exp_w = vecs[0].exp_s;

    vecs[1] = vecs[0];
    vecs[1].gap = 1'b1;

    vecs[2] = '0;

    vecs[3] = '0;
    vecs[3].k = 8'd2;
    vecs[3].din[0] = 16'hFFFF; vecs[3].win[0] = 16'hFFFF;
    vecs[3].din[1] = 16'hFFFF; vecs[3].win[1] = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      vecs[3].exp_s[i] = 16'd65535;
      vecs[3].exp_w[i] = 16'd64514;
    end

    vecs[4] = '0;
    vecs[4].k = 8'd3;
    vecs[4].rnd = 1'b1;
    vecs[4].din[0] = 16'h0401; vecs[4].win[0] = 16'h0807;
    vecs[4].din[1] = 16'h0502; vecs[4].win[1] = 16'h0A09;
    vecs[4].din[2] = 16'h0603; vecs[4].win[2] = 16'h0C0B;
    vecs[4].exp_s[0] = 16'd58;  vecs[4].exp_s[1] = 16'd64;
    vecs[4].exp_s[2] = 16'd139; vecs[4].exp_s[3] = 16'd154;
    vecs[4].exp_w = vecs[4].exp_s;

    vecs[5] = '0;
    vecs[5].k = 8'd2;
    vecs[5].rnd = 1'b1;
    vecs[5].gap = 1'b1;
    vecs[5].din[0] = 16'h01C8; vecs[5].win[0] = 16'h01C8;
    vecs[5].din[1] = 16'h01C8; vecs[5].win[1] = 16'h01C8;
    vecs[5].exp_s[0] = 16'd65535; vecs[5].exp_s[1] = 16'd400;
    vecs[5].exp_s[2] = 16'd400;   vecs[5].exp_s[3] = 16'd2;
    vecs[5].exp_w[0] = 16'd14464; vecs[5].exp_w[1] = 16'd400;
    vecs[5].exp_w[2] = 16'd400;   vecs[5].exp_w[3] = 16'd2;

    rst = 1'b0;
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    din = '0;
    win = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_busy", {a_busy, b_busy}, 2'b00);
    chk("reset_in_ready", a_in_ready, 0);
    chk("reset_out_valid", a_out_valid, 0);
    chk("reset_done", a_done, 0);
    chk("reset_out_data", a_out_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // Jobs run back-to-back: each start lands in the cycle done is high.
    for (int j = 0; j < 6; j++) begin
      cur_job = j;
      run_job(vecs[j]);
    end

    // Abort mid-FLUSH, then rerun the reference job.
    cur_job = 6;
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1;
      din = vecs[0].din[t];
      win = vecs[0].win[t];
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy_before_abort", a_busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {a_busy, b_busy}, 2'b00);
    chk("abort_out_valid", {a_out_valid, b_out_valid}, 2'b00);
    chk("abort_done", {a_done, b_done}, 2'b00);
    chk("abort_out_data", a_out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_abort", a_busy, 0);
    cur_job = 7;
    run_job(vecs[0]);
    @(negedge clk);
    chk("done_one_cycle", {a_done, b_done}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
